median_frame_ctrl: RTL and testbench
====================================

Name: median_frame_ctrl

Overview:
- Frame-level sequencer for the 3-line median filter row datapath.
- Fetches image rows from row memory, loads them into the line-window engine and starts each row filter with the correct edge mode (top/middle/bottom replication).
- Writes each filtered row back and signals frame completion.
- Sits between the host start/done interface, the row memory port and the window/median engine.

Parameters:
- ROWS, 512, number of image rows per frame (must be >= 3)
- AW, 9, row address width (2^AW >= ROWS)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  synchronous frame abort
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, frame finished
- rd_req  out  1  row read request
- rd_addr  out  AW  row index to read
- rd_ack  in  1  read accepted/data valid
- win_load  out  1  one-cycle pulse, engine shifts in the returned row
- flt_start  out  1  one-cycle pulse, engine filters current window
- flt_mode  out  2  00 TOP {L1,L1,L2}; 01 MID {L1,L2,L3}; 10 BOT {L2,L3,L3}; 11 unused
- flt_done  in  1  engine finished current row
- wr_req  out  1  filtered-row write request
- wr_addr  out  AW  output row index
- wr_ack  in  1  write accepted

Behaviour:
- Reset (RST=1, asynchronous):
  - state=IDLE; all outputs 0; fetch_row=0; out_row=0.
  - RST mid-frame abandons the frame immediately; no done pulse.
- Outputs are Moore, decoded from the registered state and counters only (no input-to-output combinational paths).
- States and outputs:
  - IDLE: start=1 -> RD, fetch_row=0, out_row=0.
  - RD: rd_req=1, rd_addr=fetch_row; held until rd_ack=1 is sampled, then -> LOAD. rd_ack is ignored in all other states.
  - LOAD: win_load=1; fetch_row+1.
    - If fetch_row was 0 -> RD.
    - Otherwise -> FLT.
  - FLT: flt_start=1 for exactly one cycle -> FWAIT.
  - FWAIT: waits for flt_done, then -> WR. flt_done is sampled only in FWAIT; an early pulse during FLT is ignored.
  - flt_mode is valid in FLT, FWAIT and WR:
    - TOP if out_row=0.
    - BOT if out_row=ROWS-1.
    - MID otherwise.
    - 00 in all other states.
  - WR: wr_req=1, wr_addr=out_row; held until wr_ack=1 is sampled. Then:
    - If out_row=ROWS-1 -> DONE.
    - Else out_row+1, then -> RD if the new out_row < ROWS-1, else -> FLT (last row, no fetch).
  - DONE: done=1 for one cycle -> IDLE.
- Frame totals: ROWS reads (rows 0..ROWS-1 in order), ROWS win_load pulses, ROWS filters, ROWS writes (rows 0..ROWS-1 in order).
- Timing:
  - Minimum latency with same-cycle acks/done: 5*ROWS+1 cycles from the edge sampling start to the done cycle.
  - A request asserted with ack already high completes in one cycle.
- abort=1 in any non-IDLE state -> IDLE at the next edge.
  - All requests drop and counters clear.
  - No done pulse.
  - abort has priority over all acks in the same cycle.
- start while busy: ignored. start and abort both high in IDLE: stay IDLE.
- Counters are AW bits wide. They never wrap within a frame; rd_addr and wr_addr never exceed ROWS-1.

Test Plan:
- ROWS=4, rd_ack/flt_done/wr_ack tied 1, start pulse:
  - rd_addr sequence 0,1,2,3.
  - flt_mode sequence TOP,MID,MID,BOT.
  - wr_addr sequence 0,1,2,3.
  - done exactly 21 cycles after start is sampled; busy low after.
- ROWS=3, random 0-5 cycle delays on rd_ack/flt_done/wr_ack:
  - rd_req/wr_req and their addresses stay stable until acked.
  - Exactly 3 reads, 3 win_load pulses, 3 writes; one done.
- flt_done pulsed during FLT and again 3 cycles into FWAIT:
  - Only the second pulse advances to WR.
  - No second flt_start.
- abort asserted while wr_req is high for out_row=2, with wr_ack=1 in the same cycle:
  - Next cycle state is IDLE, busy=0, no done.
  - Restart begins at rd_addr=0.
- RST pulsed asynchronously mid-FWAIT:
  - All outputs 0 immediately.
  - After release, a start yields a full, correct frame.
- start re-asserted every cycle during a frame:
  - No effect until IDLE.
  - Start held high at done -> a new frame begins the cycle after DONE.

Source files
------------

// File: rtl/median_frame_ctrl_if.sv
// Handshake bundle between the frame sequencer and its host, row memory and window/median engine.
// The master modport is the sequencer side; the slave modport is everything it talks to.
interface median_frame_ctrl_if #(
  parameter int AW = 9
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          win_load;
  logic          flt_start;
  logic [1:0]    flt_mode;
  logic          flt_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_ack;

  modport master (
    input  start, abort, rd_ack, flt_done, wr_ack,
    output busy, done, rd_req, rd_addr, win_load, flt_start, flt_mode, wr_req, wr_addr
  );

  modport slave (
    output start, abort, rd_ack, flt_done, wr_ack,
    input  busy, done, rd_req, rd_addr, win_load, flt_start, flt_mode, wr_req, wr_addr
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// Frame sequencer for the 3-line median filter: fetch rows, load the window, filter with edge mode, write back.
// Moore outputs registered from next state; 5*ROWS+1 cycles per frame with immediate acks; requests hold until acked.
module median_frame_ctrl #(
  parameter int ROWS = 512,
  parameter int AW   = 9
) (
  input  logic                CLK,
  input  logic                RST,
  median_frame_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LOAD,
    S_FLT,
    S_FWAIT,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [1:0]    M_TOP    = 2'b00;
  localparam logic [1:0]    M_MID    = 2'b01;
  localparam logic [1:0]    M_BOT    = 2'b10;

  state_t        state_q, state_d;
  logic [AW-1:0] fetch_row_q, fetch_row_d;
  logic [AW-1:0] out_row_q, out_row_d;
  logic [AW-1:0] out_row_inc;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          win_load_q, win_load_d;
  logic          flt_start_q, flt_start_d;
  logic [1:0]    flt_mode_q, flt_mode_d;
  logic          wr_req_q, wr_req_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;

  always_comb begin
    state_d     = state_q;
    fetch_row_d = fetch_row_q;
    out_row_d   = out_row_q;
    out_row_inc = out_row_q + AW'(1);

    if (state_q != S_IDLE && bus.abort) begin
      state_d     = S_IDLE;
      fetch_row_d = '0;
      out_row_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d     = S_RD;
            fetch_row_d = '0;
            out_row_d   = '0;
          end
        end
        S_RD:    if (bus.rd_ack) state_d = S_LOAD;
        S_LOAD: begin
          // Saturate after the last row so the fetch index never wraps.
          if (fetch_row_q != LAST_ROW) fetch_row_d = fetch_row_q + AW'(1);
          // Row 0 alone cannot form a window; fetch row 1 before the first filter.
          state_d = (fetch_row_q == '0) ? S_RD : S_FLT;
        end
        S_FLT:   state_d = S_FWAIT;
        S_FWAIT: if (bus.flt_done) state_d = S_WR;
        S_WR: begin
          if (bus.wr_ack) begin
            if (out_row_q == LAST_ROW) begin
              state_d = S_DONE;
            end else begin
              out_row_d = out_row_inc;
              state_d   = (out_row_inc < LAST_ROW) ? S_RD : S_FLT;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    rd_req_d    = (state_d == S_RD);
    rd_addr_d   = (state_d == S_RD) ? fetch_row_d : '0;
    win_load_d  = (state_d == S_LOAD);
    flt_start_d = (state_d == S_FLT);
    wr_req_d    = (state_d == S_WR);
    wr_addr_d   = (state_d == S_WR) ? out_row_d : '0;
    flt_mode_d  = 2'b00;
    if (state_d == S_FLT || state_d == S_FWAIT || state_d == S_WR) begin
      if (out_row_d == '0)           flt_mode_d = M_TOP;
      else if (out_row_d == LAST_ROW) flt_mode_d = M_BOT;
      else                           flt_mode_d = M_MID;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      fetch_row_q <= '0;
      out_row_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      win_load_q  <= 1'b0;
      flt_start_q <= 1'b0;
      flt_mode_q  <= 2'b00;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_row_q <= fetch_row_d;
      out_row_q   <= out_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      win_load_q  <= win_load_d;
      flt_start_q <= flt_start_d;
      flt_mode_q  <= flt_mode_d;
      wr_req_q    <= wr_req_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.win_load  = win_load_q;
  assign bus.flt_start = flt_start_q;
  assign bus.flt_mode  = flt_mode_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_median_frame_ctrl.sv
// Bench for median_frame_ctrl: a 4-row and a 3-row instance checked every cycle against a per-frame step list.
// Directed scenarios add literal expectations on sequences, counts and latency.
module tb_median_frame_ctrl;

  localparam int K_RD = 0, K_LD = 1, K_FLT = 2, K_FW = 3, K_WR = 4, K_DN = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  logic [1:0] start_i = '0, abort_i = '0, rd_ack_i = '0, flt_done_i = '0, wr_ack_i = '0;
  logic [1:0] busy_o, done_o, rd_req_o, win_load_o, flt_start_o, wr_req_o;
  logic [2:0] rd_addr_o [2];
  logic [2:0] wr_addr_o [2];
  logic [1:0] flt_mode_o [2];

  median_frame_ctrl_if #(.AW(3)) bus0 ();
  median_frame_ctrl_if #(.AW(3)) bus1 ();

  median_frame_ctrl #(.ROWS(4), .AW(3)) u_dut4 (.CLK(CLK), .RST(RST), .bus(bus0.master));
  median_frame_ctrl #(.ROWS(3), .AW(3)) u_dut3 (.CLK(CLK), .RST(RST), .bus(bus1.master));

  assign bus0.start = start_i[0];    assign bus1.start = start_i[1];
  assign bus0.abort = abort_i[0];    assign bus1.abort = abort_i[1];
  assign bus0.rd_ack = rd_ack_i[0];  assign bus1.rd_ack = rd_ack_i[1];
  assign bus0.flt_done = flt_done_i[0]; assign bus1.flt_done = flt_done_i[1];
  assign bus0.wr_ack = wr_ack_i[0];  assign bus1.wr_ack = wr_ack_i[1];
  assign busy_o[0] = bus0.busy;           assign busy_o[1] = bus1.busy;
  assign done_o[0] = bus0.done;           assign done_o[1] = bus1.done;
  assign rd_req_o[0] = bus0.rd_req;       assign rd_req_o[1] = bus1.rd_req;
  assign rd_addr_o[0] = bus0.rd_addr;     assign rd_addr_o[1] = bus1.rd_addr;
  assign win_load_o[0] = bus0.win_load;   assign win_load_o[1] = bus1.win_load;
  assign flt_start_o[0] = bus0.flt_start; assign flt_start_o[1] = bus1.flt_start;
  assign flt_mode_o[0] = bus0.flt_mode;   assign flt_mode_o[1] = bus1.flt_mode;
  assign wr_req_o[0] = bus0.wr_req;       assign wr_req_o[1] = bus1.wr_req;
  assign wr_addr_o[0] = bus0.wr_addr;     assign wr_addr_o[1] = bus1.wr_addr;

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0, cyc = 0;
  int rows_n[2] = '{4, 3};
  int pk[2][64];
  int pa[2][64];
  int plen[2] = '{0, 0};
  bit m_on[2] = '{0, 0};
  int m_idx[2] = '{0, 0};
  int rmode[2] = '{0, 0};
  int rdly[2] = '{0, 0}, wdly[2] = '{0, 0}, fcnt[2] = '{0, 0};
  bit fpend[2] = '{0, 0};
  int n_rd[2] = '{0, 0}, n_wl[2] = '{0, 0}, n_fs[2] = '{0, 0}, n_wr[2] = '{0, 0}, n_done[2] = '{0, 0};
  int fs_cyc[2] = '{0, 0};
  bit wr_prev[2] = '{0, 0};
  int rdq0[$], wrq0[$], mq0[$], gapq0[$], rdq1[$], wrq1[$];

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d (t=%0t)", nm, d, act, exp, $time);
    end
  endtask

  task automatic put(input int d, input int k, input int a);
    pk[d][plen[d]] = k;
    pa[d][plen[d]] = a;
    plen[d]++;
  endtask

  // Frame as a flat list of steps: prime two rows, then per output row filter/wait/write and fetch two ahead.
  task automatic build(input int d);
    int r = rows_n[d];
    put(d, K_RD, 0); put(d, K_LD, 0); put(d, K_RD, 1); put(d, K_LD, 1);
    for (int o = 0; o < r; o++) begin
      put(d, K_FLT, o); put(d, K_FW, o); put(d, K_WR, o);
      if (o + 2 <= r - 1) begin put(d, K_RD, o + 2); put(d, K_LD, o + 2); end
    end
    put(d, K_DN, 0);
  endtask

  function automatic int modeof(input int a, input int r);
    return (a == 0) ? 0 : ((a == r - 1) ? 2 : 1);
  endfunction

  function automatic bit step_advances(input int d);
    int k = pk[d][m_idx[d]];
    if (k == K_RD) return rd_ack_i[d];
    if (k == K_FW) return flt_done_i[d];
    if (k == K_WR) return wr_ack_i[d];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Reference model: advance through the step list on each clock edge.
  initial forever begin
    @(posedge CLK or posedge RST);
    for (int d = 0; d < 2; d++) begin
      if (RST) m_on[d] = 1'b0;
      else if (!m_on[d]) begin
        if (start_i[d] && !abort_i[d]) begin m_on[d] = 1'b1; m_idx[d] = 0; end
      end else if (abort_i[d]) m_on[d] = 1'b0;
      else if (step_advances(d)) begin
        if (pk[d][m_idx[d]] == K_DN) m_on[d] = 1'b0;
        else m_idx[d]++;
      end
    end
  end

  // Per-cycle compare plus transaction monitor.
  initial forever begin
    @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      int k, a;
      k = m_on[d] ? pk[d][m_idx[d]] : -1;
      a = m_on[d] ? pa[d][m_idx[d]] : 0;
      chk("busy", d, busy_o[d], int'(m_on[d]));
      chk("done", d, done_o[d], int'(k == K_DN));
      chk("rd_req", d, rd_req_o[d], int'(k == K_RD));
      chk("win_load", d, win_load_o[d], int'(k == K_LD));
      chk("flt_start", d, flt_start_o[d], int'(k == K_FLT));
      chk("wr_req", d, wr_req_o[d], int'(k == K_WR));
      chk("flt_mode", d, flt_mode_o[d], (k == K_FLT || k == K_FW || k == K_WR) ? modeof(a, rows_n[d]) : 0);
      if (k == K_RD) chk("rd_addr", d, rd_addr_o[d], a);
      if (k == K_WR) chk("wr_addr", d, wr_addr_o[d], a);
      if (RST) begin
        chk("rst_rd_addr", d, rd_addr_o[d], 0);
        chk("rst_wr_addr", d, wr_addr_o[d], 0);
      end

      if (rd_req_o[d] && rd_ack_i[d]) begin
        n_rd[d]++;
        if (d == 0) rdq0.push_back(int'(rd_addr_o[d])); else rdq1.push_back(int'(rd_addr_o[d]));
      end
      if (wr_req_o[d] && wr_ack_i[d]) begin
        n_wr[d]++;
        if (d == 0) wrq0.push_back(int'(wr_addr_o[d])); else wrq1.push_back(int'(wr_addr_o[d]));
      end
      if (win_load_o[d]) n_wl[d]++;
      if (done_o[d]) n_done[d]++;
      if (flt_start_o[d]) begin
        n_fs[d]++;
        fs_cyc[d] = cyc;
        if (d == 0) mq0.push_back(int'(flt_mode_o[d]));
      end
      if (d == 0 && wr_req_o[d] && !wr_prev[d]) gapq0.push_back(cyc - fs_cyc[d]);
      wr_prev[d] = wr_req_o[d];
    end
  end

  // Responders: 0 idle, 1 all tied high, 2 random 0-5 delays, 3 early flt_done then one 3 cycles into FWAIT.
  initial forever begin
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (RST) begin fpend[d] = 1'b0; rdly[d] = 0; wdly[d] = 0; end
      rd_ack_i[d] = 1'b0; wr_ack_i[d] = 1'b0; flt_done_i[d] = 1'b0;
      if (rmode[d] == 1) begin
        rd_ack_i[d] = 1'b1; wr_ack_i[d] = 1'b1; flt_done_i[d] = 1'b1;
      end else if (rmode[d] == 2 || rmode[d] == 3) begin
        if (rmode[d] == 3) begin
          rd_ack_i[d] = 1'b1; wr_ack_i[d] = 1'b1;
        end else begin
          if (rd_req_o[d]) begin
            if (rdly[d] == 0) begin rd_ack_i[d] = 1'b1; rdly[d] = $urandom_range(0, 5); end
            else rdly[d]--;
          end
          if (wr_req_o[d]) begin
            if (wdly[d] == 0) begin wr_ack_i[d] = 1'b1; wdly[d] = $urandom_range(0, 5); end
            else wdly[d]--;
          end
        end
        if (fpend[d]) begin
          if (fcnt[d] == 0) begin flt_done_i[d] = 1'b1; fpend[d] = 1'b0; end
          else fcnt[d]--;
        end
        if (flt_start_o[d]) begin
          fpend[d] = 1'b1;
          if (rmode[d] == 3) begin fcnt[d] = 2; flt_done_i[d] = 1'b1; end
          else fcnt[d] = $urandom_range(0, 5);
        end
      end
    end
  end

  task automatic wait_done(input int d, input int budget, input string nm);
    int n = 0;
    while (done_o[d] !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk(nm, d, done_o[d], 1);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start(input int d, output int sc);
    start_i[d] = 1'b1;
    sc = cyc + 1;
    tick();
    start_i[d] = 1'b0;
  endtask

  initial begin
    int sc, dc, b_rd, b_wr, b_m, b_g, b_fs, b_wl, b_dn, n;
    int em[4] = '{0, 1, 1, 2};
    build(0);
    build(1);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    tick();
    chk("rst_busy", 0, busy_o[0], 0);
    chk("rst_rd_req", 0, rd_req_o[0], 0);
    chk("rst_wr_req", 1, wr_req_o[1], 0);
    chk("rst_rd_addr_lit", 0, rd_addr_o[0], 0);
    chk("model_len4", 0, plen[0], 21);
    chk("model_len3", 1, plen[1], 16);

    // Four rows, everything acknowledged immediately.
    rmode[0] = 1;
    b_rd = rdq0.size(); b_wr = wrq0.size(); b_m = mq0.size(); b_g = gapq0.size();
    pulse_start(0, sc);
    wait_done(0, 200, "t1_done");
    dc = cyc;
    chk("t1_latency", 0, dc - sc + 1, 21);
    tick();
    chk("t1_busy_after", 0, busy_o[0], 0);
    chk("t1_nrd", 0, rdq0.size() - b_rd, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_addr", 0, rdq0[b_rd + i], i);
      chk("t1_mode", 0, mq0[b_m + i], em[i]);
      chk("t1_wr_addr", 0, wrq0[b_wr + i], i);
    end
    chk("t1_gap", 0, gapq0[b_g], 2);

    // Three rows, random response delays.
    rmode[1] = 2;
    b_rd = rdq1.size(); b_wr = wrq1.size(); b_wl = n_wl[1]; b_dn = n_done[1];
    pulse_start(1, sc);
    wait_done(1, 400, "t2_done");
    tick();
    chk("t2_nrd", 1, rdq1.size() - b_rd, 3);
    chk("t2_nwl", 1, n_wl[1] - b_wl, 3);
    chk("t2_nwr", 1, wrq1.size() - b_wr, 3);
    chk("t2_ndone", 1, n_done[1] - b_dn, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_rd_addr", 1, rdq1[b_rd + i], i);
      chk("t2_wr_addr", 1, wrq1[b_wr + i], i);
    end
    rmode[1] = 0;

    // Early flt_done during FLT must be ignored.
    rmode[0] = 3;
    b_fs = n_fs[0]; b_g = gapq0.size();
    pulse_start(0, sc);
    wait_done(0, 300, "t3_done");
    tick();
    chk("t3_nflt", 0, n_fs[0] - b_fs, 4);
    for (int i = 0; i < 4; i++) chk("t3_gap", 0, gapq0[b_g + i], 4);

    // Abort while writing row 2 with wr_ack in the same cycle.
    rmode[0] = 1;
    b_dn = n_done[0];
    pulse_start(0, sc);
    n = 0;
    while (!(wr_req_o[0] && wr_addr_o[0] == 3'd2) && n < 200) begin tick(); n++; end
    chk("t4_reach_wr2", 0, wr_req_o[0], 1);
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    chk("t4_busy", 0, busy_o[0], 0);
    chk("t4_wr_req", 0, wr_req_o[0], 0);
    repeat (3) tick();
    chk("t4_no_done", 0, n_done[0] - b_dn, 0);
    b_rd = rdq0.size();
    pulse_start(0, sc);
    chk("t4_restart_rd", 0, rd_req_o[0], 1);
    chk("t4_restart_addr", 0, rd_addr_o[0], 0);
    wait_done(0, 200, "t4_done");
    tick();
    chk("t4_nrd", 0, rdq0.size() - b_rd, 4);

    // Asynchronous reset in the middle of FWAIT.
    rmode[0] = 3;
    pulse_start(0, sc);
    n = 0;
    while (!flt_start_o[0] && n < 50) begin tick(); n++; end
    chk("t5_reach_flt", 0, flt_start_o[0], 1);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("t5_busy", 0, busy_o[0], 0);
    chk("t5_mode", 0, flt_mode_o[0], 0);
    chk("t5_wr_req", 0, wr_req_o[0], 0);
    chk("t5_rd_req", 0, rd_req_o[0], 0);
    rmode[0] = 1;
    b_dn = n_done[0];
    repeat (2) @(posedge CLK);
    #3 RST = 1'b0;
    tick();
    chk("t5_no_done", 0, n_done[0] - b_dn, 0);
    b_rd = rdq0.size(); b_wr = wrq0.size();
    pulse_start(0, sc);
    wait_done(0, 200, "t5_done");
    tick();
    chk("t5_nrd", 0, rdq0.size() - b_rd, 4);
    for (int i = 0; i < 4; i++) chk("t5_wr_addr", 0, wrq0[b_wr + i], i);

    // Start held high throughout.
    b_dn = n_done[0];
    start_i[0] = 1'b1;
    sc = cyc + 1;
    wait_done(0, 200, "t6_done");
    dc = cyc;
    chk("t6_latency", 0, dc - sc + 1, 21);
    tick();
    chk("t6_idle_gap", 0, busy_o[0], 0);
    tick();
    chk("t6_restart_busy", 0, busy_o[0], 1);
    chk("t6_restart_rd", 0, rd_req_o[0], 1);
    chk("t6_restart_addr", 0, rd_addr_o[0], 0);
    chk("t6_one_done", 0, n_done[0] - b_dn, 1);
    start_i[0] = 1'b0;
    abort_i[0] = 1'b1;
    tick();
    abort_i[0] = 1'b0;
    chk("t6_abort_busy", 0, busy_o[0], 0);
    start_i[0] = 1'b1;
    abort_i[0] = 1'b1;
    tick();
    start_i[0] = 1'b0;
    abort_i[0] = 1'b0;
    chk("t6_start_abort_idle", 0, busy_o[0], 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
